// File: rtl/psum_collector_if.sv
// Row-aligned partial-sum bus between the array's south edge, the collector and its consumer.
interface psum_collector_if #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16
);
  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_strobe;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_empty;
  logic [col-1:0]         o_overflow;

  modport master (
    output in, wr, rd,
    input  out, o_strobe, o_valid, o_full, o_empty, o_overflow
  );

  modport slave (
    input  in, wr, rd,
    output out, o_strobe, o_valid, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/psum_collector.sv
// Per-column FIFOs that absorb the array's diagonal skew and hand out column-aligned rows.
module psum_collector #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 64
) (
  input logic             clk,
  input logic             reset,
  psum_collector_if.slave bus
);
  localparam int unsigned    AddrW   = $clog2(depth);
  localparam logic [AddrW:0] FullCnt = (AddrW+1)'(depth);
  localparam logic [AddrW:0] OneCnt  = (AddrW+1)'(1);

  logic [psum_bw-1:0]     mem_q   [col][depth];
  logic [AddrW-1:0]       wptr_q  [col];
  logic [AddrW-1:0]       wptr_d  [col];
  logic [AddrW-1:0]       rptr_q  [col];
  logic [AddrW-1:0]       rptr_d  [col];
  logic [AddrW:0]         count_q [col];
  logic [AddrW:0]         count_d [col];
  logic [col-1:0]         ovf_q, ovf_d, wr_ok;
  logic [psum_bw*col-1:0] out_q, head;
  logic                   strobe_q, pop, all_valid, any_full, all_empty;

  always_comb begin
    all_valid = 1'b1;
    any_full  = 1'b0;
    all_empty = 1'b1;
    for (int c = 0; c < col; c++) begin
      if (count_q[c] == '0) all_valid = 1'b0;
      else                  all_empty = 1'b0;
      if (count_q[c] == FullCnt) any_full = 1'b1;
    end
  end

  assign pop = bus.rd & all_valid;

  always_comb begin
    head  = '0;
    ovf_d = ovf_q;
    wr_ok = '0;
    for (int c = 0; c < col; c++) begin
      wptr_d[c]  = wptr_q[c];
      rptr_d[c]  = rptr_q[c];
      count_d[c] = count_q[c];
      head[c*psum_bw +: psum_bw] = mem_q[c][rptr_q[c]];
      // A pop in the same cycle frees the slot, so a full column still accepts the write.
      wr_ok[c] = bus.wr[c] & ((count_q[c] != FullCnt) | pop);
      if (bus.wr[c] & ~wr_ok[c]) ovf_d[c] = 1'b1;
      if (wr_ok[c]) wptr_d[c] = wptr_q[c] + AddrW'(1);
      if (pop)      rptr_d[c] = rptr_q[c] + AddrW'(1);
      case ({wr_ok[c], pop})
        2'b10:   count_d[c] = count_q[c] + OneCnt;
        2'b01:   count_d[c] = count_q[c] - OneCnt;
        default: count_d[c] = count_q[c];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
      end
      ovf_q    <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        count_q[c] <= count_d[c];
      end
      ovf_q    <= ovf_d;
      strobe_q <= pop;
      if (pop) out_q <= head;
    end
  end

  // Storage needs no reset: pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (wr_ok[c]) mem_q[c][wptr_q[c]] <= bus.in[c*psum_bw +: psum_bw];
    end
  end

  assign bus.out        = out_q;
  assign bus.o_strobe   = strobe_q;
  assign bus.o_valid    = all_valid;
  assign bus.o_full     = any_full;
  assign bus.o_empty    = all_empty;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench: skew table, full/overflow, async reset, full+pop and wrap-around sequences.
module tb_psum_collector;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int W     = COL * BW;
  localparam int DEPTH = 64;

  typedef struct {
    logic [COL-1:0] wr;
    logic           rd;
    logic [W-1:0]   din;
    logic           exp_strobe;
    logic           exp_valid;
    logic           exp_empty;
    logic [W-1:0]   exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  psum_collector_if #(.col(COL), .psum_bw(BW)) bus ();

  psum_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int             n_vec = 0;
  int             n_err = 0;
  logic [BW-1:0]  mq [COL][$];
  logic [W-1:0]   sb [$];
  logic [COL-1:0] movf = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] row_of(input int k);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = 16'(16'h0100 * c + k);
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < COL; c++) mq[c].delete();
    sb.delete();
    movf = '0;
  endtask

  // One clock of stimulus; the model predicts the pop and queues the expected row.
  task automatic drive_cycle(input logic [COL-1:0] w, input logic r, input logic [W-1:0] d,
                             output bit pop_ok);
    logic [W-1:0] row;
    bit           was_full [COL];
    bit           m_valid, m_full, m_empty;
    pop_ok = r;
    for (int c = 0; c < COL; c++) begin
      if (mq[c].size() == 0) pop_ok = 1'b0;
      was_full[c] = (mq[c].size() == DEPTH);
    end
    if (pop_ok) begin
      for (int c = 0; c < COL; c++) row[c*BW +: BW] = mq[c].pop_front();
      sb.push_back(row);
    end
    for (int c = 0; c < COL; c++) begin
      if (w[c]) begin
        if (!was_full[c] || pop_ok) mq[c].push_back(d[c*BW +: BW]);
        else movf[c] = 1'b1;
      end
    end
    bus.wr = w;
    bus.rd = r;
    bus.in = d;
    @(posedge clk);
    #1;
    bus.wr = '0;
    bus.rd = 1'b0;
    check("strobe", W'(bus.o_strobe), W'(pop_ok));
    if (pop_ok) check("sb_out", bus.out, sb.pop_front());
    m_valid = 1'b1;
    m_full  = 1'b0;
    m_empty = 1'b1;
    for (int c = 0; c < COL; c++) begin
      if (mq[c].size() == 0) m_valid = 1'b0;
      else m_empty = 1'b0;
      if (mq[c].size() == DEPTH) m_full = 1'b1;
    end
    check("valid", W'(bus.o_valid), W'(m_valid));
    check("full", W'(bus.o_full), W'(m_full));
    check("empty", W'(bus.o_empty), W'(m_empty));
    check("overflow", W'(bus.o_overflow), W'(movf));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"}, bus.out, '0);
    check({tag, "_strobe"}, W'(bus.o_strobe), W'(0));
    check({tag, "_ovf"}, W'(bus.o_overflow), W'(0));
    check({tag, "_empty"}, W'(bus.o_empty), W'(1));
    check({tag, "_valid"}, W'(bus.o_valid), W'(0));
    check({tag, "_full"}, W'(bus.o_full), W'(0));
  endtask

  initial begin
    vec_t         tbl [16];
    bit           p;
    logic [W-1:0] d;
    logic [W-1:0] held;
    int           w_idx, popped, guard, occ;
    bit           do_wr, do_rd;

    bus.in = '0;
    bus.wr = '0;
    bus.rd = 1'b0;

    // Diagonal skew: column c gets 0x100*c+k at cycle c+k, then four pops and one ignored read.
    for (int i = 0; i < 11; i++) begin
      tbl[i].wr = '0;
      tbl[i].din = '0;
      for (int c = 0; c < COL; c++) begin
        if (i - c >= 0 && i - c <= 3) begin
          tbl[i].wr[c] = 1'b1;
          tbl[i].din[c*BW +: BW] = 16'(16'h0100 * c + (i - c));
        end
      end
      tbl[i].rd = 1'b0;
      tbl[i].exp_strobe = 1'b0;
      tbl[i].exp_valid = (i >= 7);
      tbl[i].exp_empty = 1'b0;
      tbl[i].exp_out = '0;
    end
    for (int k = 0; k < 4; k++) begin
      tbl[11+k].wr = '0;
      tbl[11+k].din = '0;
      tbl[11+k].rd = 1'b1;
      tbl[11+k].exp_strobe = 1'b1;
      tbl[11+k].exp_valid = (k < 3);
      tbl[11+k].exp_empty = (k == 3);
      tbl[11+k].exp_out = row_of(k);
    end
    tbl[15].wr = '0;
    tbl[15].din = '0;
    tbl[15].rd = 1'b1;
    tbl[15].exp_strobe = 1'b0;
    tbl[15].exp_valid = 1'b0;
    tbl[15].exp_empty = 1'b1;
    tbl[15].exp_out = row_of(3);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("init");

    for (int i = 0; i < 16; i++) begin
      drive_cycle(tbl[i].wr, tbl[i].rd, tbl[i].din, p);
      check($sformatf("tbl%0d_strobe", i), W'(bus.o_strobe), W'(tbl[i].exp_strobe));
      check($sformatf("tbl%0d_valid", i), W'(bus.o_valid), W'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_empty", i), W'(bus.o_empty), W'(tbl[i].exp_empty));
      check($sformatf("tbl%0d_out", i), bus.out, tbl[i].exp_out);
    end

    // Ignored read right after writing only seven columns.
    held = bus.out;
    drive_cycle(8'h7F, 1'b0, {8{16'h55A0}}, p);
    drive_cycle(8'h00, 1'b1, '0, p);
    check("ign_strobe", W'(bus.o_strobe), W'(0));
    check("ign_out", bus.out, held);
    check("ign_valid", W'(bus.o_valid), W'(0));
    drive_cycle(8'h80, 1'b0, {8{16'h55A7}}, p);
    check("ign_valid_after", W'(bus.o_valid), W'(1));
    drive_cycle(8'h00, 1'b1, '0, p);
    check("ign_row", bus.out, {16'h55A7, {7{16'h55A0}}});
    check("ign_empty", W'(bus.o_empty), W'(1));

    // Fill, overflow column 3, drain.
    for (int k = 0; k < DEPTH; k++) drive_cycle(8'hFF, 1'b0, row_of(k), p);
    check("fill_full", W'(bus.o_full), W'(1));
    drive_cycle(8'h08, 1'b0, {8{16'hDEAD}}, p);
    check("ovf_col3", W'(bus.o_overflow), W'(8'h08));
    for (int k = 0; k < DEPTH; k++) drive_cycle(8'h00, 1'b1, '0, p);
    check("drain_last", bus.out, row_of(63));
    check("drain_empty", W'(bus.o_empty), W'(1));

    // Async reset mid-cycle with data buffered.
    for (int k = 0; k < 3; k++) drive_cycle(8'hFF, 1'b0, row_of(k + 7), p);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check_reset_state("post");

    // Full with a simultaneous pop and write.
    for (int k = 0; k < DEPTH; k++) drive_cycle(8'hFF, 1'b0, row_of(k), p);
    drive_cycle(8'hFF, 1'b1, {8{16'hBEEF}}, p);
    check("fp_row0", bus.out, row_of(0));
    check("fp_full", W'(bus.o_full), W'(1));
    check("fp_ovf", W'(bus.o_overflow), W'(0));
    for (int k = 0; k < DEPTH; k++) drive_cycle(8'h00, 1'b1, '0, p);
    check("fp_beef", bus.out, {8{16'hBEEF}});
    check("fp_empty", W'(bus.o_empty), W'(1));

    // Wrap-around with occupancy kept between 1 and 10.
    w_idx = 0;
    popped = 0;
    guard = 0;
    while (popped < 200 && guard < 3000) begin
      occ = mq[0].size();
      do_wr = (w_idx < 200) && (occ < 10) && (occ == 0 || $urandom_range(0, 2) != 0);
      do_rd = (occ > 1 && $urandom_range(0, 1) == 1) || (w_idx >= 200 && occ > 0);
      d = {8{16'(w_idx)}};
      drive_cycle(do_wr ? 8'hFF : 8'h00, do_rd, d, p);
      if (do_wr) w_idx++;
      if (p) begin
        check("wrap_order", bus.out, {8{16'(popped)}});
        popped++;
      end
      guard++;
    end
    check("wrap_count", W'(popped), W'(200));
    check("wrap_ovf", W'(bus.o_overflow), W'(0));
    check("wrap_empty", W'(bus.o_empty), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/psum_collector.md
# psum_collector

South-edge receiver for the systolic MAC array. It captures the per-column partial sums the array emits on `out_s`, qualified by the per-column `valid` bits. Column outputs arrive skewed in time (column c lags column c-1), so the collector buffers each column in its own FIFO. It re-presents complete, column-aligned rows to the downstream consumer (SFU / memory writeback) through a read-request interface.

## Interface

Parameters:
- `col`, 8, number of array columns (one FIFO per column)
- `psum_bw`, 16, partial-sum width per column
- `depth`, 64, entries per column FIFO; power of 2, ≥ 2

Ports:
- `clk`, input, 1, single clock; all state on rising edge
- `reset`, input, 1, asynchronous, active-high; clears all state
- `in`, input, `psum_bw*col`, column c at bits `[psum_bw*(c+1)-1 : psum_bw*c]`; driven by array `out_s`
- `wr`, input, `col`, per-column write strobe; driven by array `valid`
- `rd`, input, 1, request to pop one aligned row
- `out`, output, `psum_bw*col`, registered popped row, same column packing as `in`
- `o_strobe`, output, 1, high for exactly one cycle when `out` carries a newly popped row
- `o_valid`, output, 1, every column FIFO is non-empty
- `o_full`, output, 1, at least one column FIFO is full
- `o_empty`, output, 1, every column FIFO is empty
- `o_overflow`, output, `col`, sticky per-column flag: a write to that column was dropped

## Operation

- Per column c: circular buffer of `depth` × `psum_bw`.
  - Write and read pointers are `log2(depth)` bits wide and wrap naturally.
  - Occupancy counter is `log2(depth)+1` bits, range 0..depth.
- Write:
  - At a rising edge with `wr[c]=1`, store `in[c]` at `wptr[c]` and advance `wptr[c]`.
  - Columns are written independently. Any subset of columns may write in the same cycle.
- Write to a full column (`count[c]==depth`) with no accepted pop in the same cycle:
  - Data is dropped; pointer and count are unchanged.
  - `o_overflow[c]` is set to 1 and stays 1 until reset.
- Pop accepted when `rd && o_valid`, evaluated before the edge.
  - At that edge, `out` is loaded with the head entry of every column and every `rptr` advances by 1.
  - `o_strobe` is 1 in the following cycle and 0 otherwise.
- `rd` while `o_valid=0` is ignored: `out` holds its value and `o_strobe=0`.
- Simultaneous write to column c and accepted pop:
  - Both take effect; `count[c]` is unchanged.
  - This applies when `count[c]==depth`: the write is accepted, no overflow.
  - When `count[c]==0` the pop cannot be accepted (`o_valid=0`), so only the write occurs.
- Flags are combinational from the registered counts:
  - `o_valid` = AND over columns of (`count>0`)
  - `o_full` = OR over columns of (`count==depth`)
  - `o_empty` = AND over columns of (`count==0`)
- FIFO order is preserved per column. Row k of `out` is the k-th value written to each column, regardless of arrival skew.
- No arithmetic on data. Values pass through bit-exact.

## Timing

- Reset (async assert, sync-to-clock deassert is external):
  - all pointers and counts = 0
  - `out` = 0, `o_strobe` = 0, `o_overflow` = 0
  - hence `o_valid` = 0, `o_full` = 0, `o_empty` = 1
- Reset mid-operation discards all buffered data immediately. No pop completes in the reset cycle.
- Write-to-visible latency: a write at edge T updates the flags after edge T. The earliest accepted pop is at edge T+1, with data on `out` after edge T+1.
- Read latency: 1 cycle, from the `rd` sampling edge to `out`/`o_strobe`.
- Throughput: one row per cycle under continuous `rd`. One write per column per cycle.
- Skew: with the array's diagonal `valid`, `o_valid` first rises the cycle after column `col-1` receives its first write.

## Test plan

- Reset: assert `reset` asynchronously mid-cycle.
  - Required: `out=0`, `o_strobe=0`, `o_overflow=0`, `o_empty=1`, `o_valid=0`, `o_full=0` without waiting for a clock edge.
- Skewed writes: column c receives value `16'h0100*c + k` for k=0..3 at cycles t+c+k (diagonal).
  - Required: `o_valid` stays 0 until after cycle t+7.
  - Four pops then return rows with column c = `0x0100*c + k`, `o_strobe` high for each. After that `o_empty=1`.
- Full/overflow: write 64 entries to all columns, then a 65th to column 3 only.
  - Required: `o_full=1` after the 64th write, `o_overflow=8'b0000_1000`.
  - The subsequent 64 pops return entries 0..63; the 65th value never appears.
- Full with simultaneous pop: all columns full, assert `rd` and `wr=8'hFF` with value `0xBEEF` in the same cycle.
  - Required: `o_overflow` stays 0, `o_full` stays 1.
  - The popped row is entry 0. `0xBEEF` is returned as the 64th subsequent pop.
- Wrap-around: 200 writes/pops interleaved, keeping occupancy between 1 and 10, with data = index.
  - Required: pops return 0..199 in order on every column; no overflow.
- Ignored read: `rd=1` while `o_valid=0`, including right after a write to only 7 columns.
  - Required: `o_strobe=0`, `out` unchanged, all counts unchanged.
